// File: rtl/adder_sum_stage_pkg.sv
// Shared widths and buffer state encoding for the adder sum stage and its
// 2-entry output buffer.
package adder_sum_stage_pkg;

    localparam int LEN_DATA = 64;
    localparam int LEN_TAG  = 6;

    // Result record: {sum, cout, zero, neg, ovf, tag}
    function automatic int rec_width(input int len_data, input int len_tag);
        return len_data + 4 + len_tag;
    endfunction

    localparam int LEN_REC = rec_width(LEN_DATA, LEN_TAG);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage : adder_sum_stage_pkg

// File: rtl/adder_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. Both in_ready and out_valid are
// registered, so no combinational path runs from out_ready to in_ready.
module adder_skid_buf
    import adder_sum_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    buf_state_t       state;
    logic [WIDTH-1:0] main_p1;
    logic [WIDTH-1:0] skid_p1;
    logic             push;
    logic             pop;

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_data = main_p1;

    // main_p1 always holds the oldest entry; skid_p1 only fills while stalled in ONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BUF_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_p1   <= '0;
            skid_p1   <= '0;
        end else if (flush) begin
            state     <= BUF_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                BUF_EMPTY: begin
                    if (push) begin
                        main_p1   <= in_data;
                        state     <= BUF_ONE;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (push && pop) begin
                        main_p1 <= in_data;
                    end else if (push) begin
                        skid_p1  <= in_data;
                        state    <= BUF_TWO;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        state     <= BUF_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                BUF_TWO: begin
                    if (pop) begin
                        main_p1  <= skid_p1;
                        state    <= BUF_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= BUF_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule : adder_skid_buf

// File: rtl/adder_sum_stage.sv
// Final stage of the 64-bit prefix adder: forms sum, carry-out and ALU flags
// from the group generates and registers them through a 2-entry skid buffer.
module adder_sum_stage
    import adder_sum_stage_pkg::*;
#(
    parameter int LEN_DATA = adder_sum_stage_pkg::LEN_DATA,
    parameter int LEN_TAG  = adder_sum_stage_pkg::LEN_TAG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN_DATA-1:0] generate_in,
    input  logic [LEN_DATA-1:0] half_sum_in,
    input  logic                cin,
    input  logic                sub_in,
    input  logic [LEN_TAG-1:0]  tag_in,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] sum_out,
    output logic                cout_out,
    output logic                zero_out,
    output logic                neg_out,
    output logic                ovf_out,
    output logic [LEN_TAG-1:0]  tag_out
);

    localparam int WIDTH = rec_width(LEN_DATA, LEN_TAG);

    // Carry into bit i is the group generate of bit i-1; cin enters at bit 0
    // and G[MSB] becomes the carry out of the word.
    function automatic logic [LEN_DATA:0] carry_vec(input logic [LEN_DATA-1:0] gen,
                                                    input logic                cin_bit);
        return {gen, cin_bit};
    endfunction

    logic [LEN_DATA:0]   carry_p0;
    logic [LEN_DATA-1:0] sum_p0;
    logic                cout_p0;
    logic                zero_p0;
    logic                neg_p0;
    logic                ovf_p0;
    logic [WIDTH-1:0]    rec_p0;
    logic [WIDTH-1:0]    rec_p1;

    // p0: combinational sum and flags
    assign carry_p0 = carry_vec(generate_in, cin);
    assign sum_p0   = half_sum_in ^ carry_p0[LEN_DATA-1:0];
    assign cout_p0  = carry_p0[LEN_DATA] ^ sub_in;
    assign ovf_p0   = carry_p0[LEN_DATA-1] ^ carry_p0[LEN_DATA];
    assign zero_p0  = ~|sum_p0;
    assign neg_p0   = sum_p0[LEN_DATA-1];
    assign rec_p0   = {sum_p0, cout_p0, zero_p0, neg_p0, ovf_p0, tag_in};

    // p1: registered result held in the skid buffer
    adder_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (rec_p0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (rec_p1)
    );

    assign {sum_out, cout_out, zero_out, neg_out, ovf_out, tag_out} = rec_p1;

endmodule : adder_sum_stage

// File: doc/adder_sum_stage.md
Name: adder_sum_stage

Overview:
- Final, registered stage of the 64-bit parallel-prefix adder. Sits directly downstream of the last prefix stage (stage 7).
- Consumes group-generate vectors (bit 0..i, carry-in already folded into bit 0) and the per-bit half-sum. Produces sum, carry-out and ALU flags.
- Holds results in a 2-entry skid buffer with valid/ready handshake, so the ALU write-back can stall without a combinational ready path back into the prefix tree.

Parameters:
- LEN_DATA, 64 (from main.def.v), operand/sum width.
- LEN_TAG, 6, width of the opaque operation tag carried alongside the data.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream data valid
- in_ready  out  1  stage can accept this cycle
- generate_in  in  LEN_DATA  group generate G[i] = carry out of bit i
- half_sum_in  in  LEN_DATA  a[i]^b[i]
- cin  in  1  adder carry-in
- sub_in  in  1  op is subtract; affects carry-out sense only
- tag_in  in  LEN_TAG  op tag
- flush  in  1  discard all held results
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- sum_out  out  LEN_DATA  sum
- cout_out  out  1  carry out (borrow-inverted when sub)
- zero_out  out  1  sum == 0
- neg_out  out  1  sum[LEN_DATA-1]
- ovf_out  out  1  signed overflow
- tag_out  out  LEN_TAG  tag of the result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On rst, both buffer entries are invalid, out_valid=0, in_ready=1, and all data outputs are 0.
- Carry derivation: c[0]=cin, c[i]=G[i-1] for 1..LEN_DATA-1, c[LEN_DATA]=G[LEN_DATA-1].
- Sum: sum[i]=half_sum_in[i]^c[i].
- Carry-out: cout=c[LEN_DATA]^sub_in, so it reads as borrow for subtract.
- Overflow: ovf=c[LEN_DATA-1]^c[LEN_DATA].
- Zero flag: zero = ~|sum.
- Neg flag: neg = sum[MSB].
- All results are computed combinationally, then registered. Latency is 1 cycle from accepted input to out_valid when the buffer is empty.
- Handshake: transfer in on in_valid&in_ready; transfer out on out_valid&out_ready. Data is stable while out_valid&~out_ready.
- Buffer state machine (entries held):
  - EMPTY: accept → ONE.
  - ONE: accept and no output → TWO. Accept and output → ONE, new data loaded. Output only → EMPTY.
  - TWO: in_ready=0. Output → ONE, the skid entry is promoted to the output register.
- in_ready is a registered signal equal to (state!=TWO). It has no combinational dependency on out_ready.
- Ordering: results leave strictly in acceptance order. Simultaneous in and out transfers in ONE keep occupancy constant.
- Flush: takes effect next cycle. State → EMPTY and out_valid → 0. An input offered in the flush cycle is dropped. Flush has priority over everything except rst.
- rst mid-stall: the held entries are lost. No partial output.

Decomposition:
- main.def.v holds LEN_DATA, LEN_TAG, and a packed result-record width constant (sum+cout+zero+neg+ovf+tag).
- One sub-module, adder_skid_buf. It is a generic 2-entry valid/ready buffer over a WIDTH-bit payload, reusable by the other ALU output stages.
- Flag and sum logic stays in adder_sum_stage.

Test Plan:
The bench drives operands through a prefix golden model to produce generate_in and half_sum_in.
- Increment wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0, cout=1, zero=1, ovf=0, out_valid one cycle after accept.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1 → sum=0x8000_0000_0000_0000, neg=1, ovf=1, cout=0.
- Subtract: a=5, b=~6, cin=1, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFF, cout=1 (borrow), neg=1.
- Back-pressure: tags 1,2,3 sent back-to-back with out_ready=0 → in_ready drops after 2 accepts. Raising out_ready delivers tags 1,2,3 in order, with no loss or duplication.
- Flush with both entries full → out_valid=0 next cycle, in_ready=1. The next input is output alone.
- rst asserted while in state TWO → all outputs 0, out_valid=0, in_ready=1 on the following cycle.
